// File: rtl/display_arb_pkg.sv
// Shared types and constants for the display arbiter.
// The arbiter's optional source-0 priority mode is enabled by defining DISPLAY_ARB_PRIO_EN.
package display_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NUM_SRC = 4;
    localparam logic [31:0] BLANK_WORD = 32'h0;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: the first set request after 'last' wins.
module rr_pick
    import display_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last,
    output logic               valid,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    // Walk from the farthest candidate (last itself) to the nearest so the nearest wins.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of one 8-digit display between four BCD sources, with blank gaps.
// Define DISPLAY_ARB_PRIO_EN to make source 0 preempt and hold the display.
//
//   state | meaning
//   IDLE  | no request; display blanked, no grant
//   BLANK | new grant issued; anti-ghosting gap counting 0..BLANK_CYC
//   SHOW  | granted word shown; dwell counter running unless hold
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned DWELL_MAX = 200_000_000 - 1,
    parameter int unsigned BLANK_CYC = 100_000 - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   req,
    input  logic [31:0]          data0,
    input  logic [31:0]          data1,
    input  logic [31:0]          data2,
    input  logic [31:0]          data3,
    input  logic                 hold,
    output logic [NUM_SRC-1:0]   grant,
    output logic [1:0]           grant_id,
    output logic [31:0]          display,
    output logic                 blank,
    output logic                 switch_pulse
);

    localparam logic [27:0] DWELL_END = 28'(DWELL_MAX);
    localparam logic [16:0] GAP_END   = 17'(BLANK_CYC);

    state_t               state, state_nxt;
    logic [27:0]          dwell_cnt, dwell_nxt;
    logic [16:0]          gap_cnt, gap_nxt;
    logic [NUM_SRC-1:0]   grant_nxt;
    logic [1:0]           grant_id_nxt, last, last_nxt;
    logic                 pulse_nxt, blank_nxt;
    logic [31:0]          display_nxt, data_sel;
    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic                 cur_req, others_req, expire, preempt, keep_src0, do_arb;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        case (grant_id_nxt)
            2'd0:    data_sel = data0;
            2'd1:    data_sel = data1;
            2'd2:    data_sel = data2;
            default: data_sel = data3;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        dwell_nxt    = dwell_cnt;
        gap_nxt      = gap_cnt;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        last_nxt     = last;
        pulse_nxt    = 1'b0;
        do_arb       = 1'b0;
        cur_req      = req[grant_id];
        others_req   = |(req & ~grant);
        expire       = (dwell_cnt == DWELL_END) && !hold;
`ifdef DISPLAY_ARB_PRIO_EN
        preempt      = req[0] && (grant_id != 2'd0) && (state != IDLE);
        keep_src0    = (grant_id == 2'd0);
`else
        preempt      = 1'b0;
        keep_src0    = 1'b0;
`endif

        if (preempt) begin
            // Urgent grant deliberately leaves 'last' alone so rotation resumes afterwards.
            grant_nxt    = onehot(2'd0);
            grant_id_nxt = 2'd0;
            pulse_nxt    = 1'b1;
            state_nxt    = BLANK;
            gap_nxt      = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) do_arb = 1'b1;
                end
                BLANK: begin
                    if (!cur_req) begin
                        do_arb = 1'b1;
                    end else if (gap_cnt == GAP_END) begin
                        state_nxt = SHOW;
                        dwell_nxt = '0;
                    end else begin
                        gap_nxt = gap_cnt + 17'd1;
                    end
                end
                SHOW: begin
                    if (!cur_req) begin
                        do_arb = 1'b1;
                    end else if (expire) begin
                        if (others_req && !keep_src0) do_arb = 1'b1;
                        else                          dwell_nxt = '0;
                    end else if (!hold) begin
                        dwell_nxt = dwell_cnt + 28'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (do_arb) begin
                if (pick_valid) begin
                    grant_nxt    = onehot(pick_idx);
                    grant_id_nxt = pick_idx;
                    last_nxt     = pick_idx;
                    pulse_nxt    = 1'b1;
                    state_nxt    = BLANK;
                    gap_nxt      = '0;
                end else begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                    dwell_nxt = '0;
                end
            end
        end

        blank_nxt   = (state_nxt != SHOW);
        display_nxt = (state_nxt == SHOW) ? data_sel : BLANK_WORD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            grant        <= '0;
            grant_id     <= 2'd0;
            last         <= 2'd3;
            display      <= BLANK_WORD;
            blank        <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            dwell_cnt    <= dwell_nxt;
            gap_cnt      <= gap_nxt;
            grant        <= grant_nxt;
            grant_id     <= grant_id_nxt;
            last         <= last_nxt;
            display      <= display_nxt;
            blank        <= blank_nxt;
            switch_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a per-cycle reference model of the grant schedule.
// Exercises the DISPLAY_ARB_PRIO_EN scenario only when that macro is defined.
module tb_display_arbiter;

    localparam int DWELL_MAX = 9;
    localparam int BLANK_CYC = 1;
`ifdef DISPLAY_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk, rst_n, hold;
    logic [3:0]  req;
    logic [31:0] dat [4];
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic [31:0] display;
    logic        blank, switch_pulse;

    int n_vec = 0;
    int n_bad = 0;

    display_arbiter #(.DWELL_MAX(DWELL_MAX), .BLANK_CYC(BLANK_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .data0        (dat[0]),
        .data1        (dat[1]),
        .data2        (dat[2]),
        .data3        (dat[3]),
        .hold         (hold),
        .grant        (grant),
        .grant_id     (grant_id),
        .display      (display),
        .blank        (blank),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_cur is the granted source (-1 when idle), m_gap_left the blank
    // cycles still to come, m_dwell the non-held SHOW cycles already spent.
    int          m_cur, m_last, m_id, m_gap_left, m_dwell;
    logic [31:0] e_display;
    logic        e_pulse;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = -1; m_last = 3; m_id = 0; m_gap_left = 0; m_dwell = 0;
            e_display = 32'h0; e_pulse = 1'b0;
        end else begin
            int w;
            bit arb;
            arb = 1'b0;
            e_pulse = 1'b0;
            if (m_cur < 0) begin
                arb = (req != 4'b0);
            end else if (PRIO && req[0] && m_cur != 0) begin
                m_cur = 0; m_id = 0; e_pulse = 1'b1; m_gap_left = BLANK_CYC + 1;
            end else if (!req[m_cur]) begin
                arb = 1'b1;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
                m_dwell = 0;
            end else if (!hold) begin
                m_dwell++;
                if (m_dwell > DWELL_MAX) begin
                    m_dwell = 0;
                    if ((req & ~(4'b0001 << m_cur)) != 4'b0 && !(PRIO && m_cur == 0)) arb = 1'b1;
                end
            end
            if (arb) begin
                w = pick(req, m_last);
                if (w < 0) m_cur = -1;
                else begin
                    m_cur = w; m_id = w; m_last = w; e_pulse = 1'b1;
                    m_gap_left = BLANK_CYC + 1; m_dwell = 0;
                end
            end
            e_display = (m_cur >= 0 && m_gap_left == 0) ? dat[m_cur] : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] e_grant;
            logic       e_blank;
            e_grant = (m_cur < 0) ? 4'b0 : (4'b0001 << m_cur);
            e_blank = !(m_cur >= 0 && m_gap_left == 0);
            n_vec++;
            if (grant !== e_grant || grant_id !== 2'(m_id) || blank !== e_blank ||
                display !== e_display || switch_pulse !== e_pulse) begin
                n_bad++;
                $display("FAIL model t=%0t: grant=%b/%b id=%0d/%0d blank=%b/%b display=%h/%h pulse=%b/%b (actual/required)",
                         $time, grant, e_grant, grant_id, m_id, blank, e_blank,
                         display, e_display, switch_pulse, e_pulse);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_show(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (blank && k < 20);
        check(name, 32'(blank), 32'd0);
    endtask

    int np, shows0, show_cnt, got, blanks;
    logic [1:0]  ids [4];
    logic [31:0] disp2;

    initial begin
        rst_n = 1'b0; req = 4'b0; hold = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 32'h0;
        dat[1] = 32'h1111_0001;
        dat[3] = 32'h0033_3300;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (20) @(negedge clk);
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_blank", 32'(blank), 32'h1);
        check("idle_display", display, 32'h0);

        // Two-source rotation 0 -> 2 -> 0
        dat[0] = 32'h4800_0000; dat[2] = 32'h0000_1234; req = 4'b0101;
        np = 0; shows0 = 0; disp2 = 32'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (switch_pulse) begin
                if (np < 4) ids[np] = grant_id;
                np++;
            end
            if (i < 12 && !blank && display == 32'h4800_0000) shows0++;
            if (i == 20) disp2 = display;
        end
        check("rot_pulses", 32'(np), 32'd3);
        check("rot_id0", 32'(ids[0]), 32'd0);
        check("rot_id1", 32'(ids[1]), 32'd2);
        check("rot_id2", 32'(ids[2]), 32'd0);
        check("rot_show0_cycles", 32'(shows0), 32'd10);
        check("rot_display2", disp2, 32'h0000_1234);
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Single requester keeps the display without re-blanking
        req = 4'b0010;
        np = 0; blanks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (switch_pulse) np++;
            if (blank) blanks++;
        end
        check("solo_pulses", 32'(np), 32'd1);
        check("solo_blanks", 32'(blanks), 32'd2);
        req = 4'b0;
        repeat (2) @(negedge clk);

        // Hold stretches grant 1 to 40 SHOW cycles, then source 3 takes over
        req = 4'b0010;
        wait_show("hold_wait_show");
        show_cnt = 1;
        req = 4'b1010; hold = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (!blank && grant == 4'b0010) show_cnt++;
        end
        hold = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (switch_pulse) got = 1;
            else if (!blank && grant == 4'b0010) show_cnt++;
        end
        check("hold_pulse_seen", 32'(got), 32'd1);
        check("hold_show_cycles", 32'(show_cnt), 32'd40);
        check("hold_next_id", 32'(grant_id), 32'd3);

        // Granted source drops during BLANK: re-arbitrate to source 2
        req = 4'b0100;
        @(negedge clk);
        check("blank_drop_grant", 32'(grant), 32'h4);
        check("blank_drop_pulse", 32'(switch_pulse), 32'h1);
        wait_show("drop_wait_show");
        repeat (3) @(negedge clk);
        req = 4'b0;
        @(negedge clk);
        check("show_drop_grant", 32'(grant), 32'h0);
        check("show_drop_blank", 32'(blank), 32'h1);

        // Asynchronous reset mid-SHOW, then restart from source 0
        req = 4'b0001;
        wait_show("rst_wait_show");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_display", display, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0011;
        @(negedge clk);
        check("rst_restart_pulse", 32'(switch_pulse), 32'h1);
        check("rst_restart_id", 32'(grant_id), 32'd0);

`ifdef DISPLAY_ARB_PRIO_EN
        req = 4'b1000;
        @(negedge clk);
        check("prio_pre_grant", 32'(grant), 32'h8);
        wait_show("prio_wait_show3");
        req = 4'b1001;
        @(negedge clk);
        check("prio_preempt_grant", 32'(grant), 32'h1);
        check("prio_preempt_pulse", 32'(switch_pulse), 32'h1);
        wait_show("prio_wait_show0");
        check("prio_display0", display, 32'h4800_0000);
        repeat (15) @(negedge clk);
        check("prio_keeps_grant", 32'(grant), 32'h1);
        req = 4'b1000;
        @(negedge clk);
        check("prio_resume_id", 32'(grant_id), 32'd3);
`endif

        req = 4'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
